// File: rtl/mem_dma_master.sv
// mem_dma_master
// ---------------------------------------------------------------------------
// Bus initiator that copies a block of 32-bit words from a source to a
// destination address over the core memory interface. Each word is one
// read request followed by one write request. A request stays up until the
// responder pulses mem_ack.
//
// Handshake: a request (mem_read or mem_write) is held with a stable
// mem_addr/mem_write_data until mem_ack is sampled high on a rising edge;
// that edge completes the transfer. The request outputs are masked by
// mem_ack so the responder never sees a request in its own ack cycle, and
// read and write are never requested together.
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   start, abort         command launch (sampled in IDLE) / stop request
//   src_addr, dst_addr   byte addresses of first source / destination word
//   word_count           number of words to copy
//   busy, done, error    status: busy while active, one-cycle done pulse,
//                        sticky error (misalignment or timeout)
//   xfer_count           words fully written in the current/last command
//   mem_*                memory bus requester side
//   dbg_state            current FSM state (0 IDLE, 1 RD, 2 WR, 3 DONE)
// ---------------------------------------------------------------------------
module mem_dma_master #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] xfer_count,
    output logic             mem_read,
    output logic             mem_write,
    input  logic             mem_ack,
    output logic [31:0]      mem_addr,
    input  logic [31:0]      mem_read_data,
    output logic [31:0]      mem_write_data,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int                TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [31:0]        src_q, src_d;
    logic [31:0]        dst_q, dst_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        buf_q, buf_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   xfer_q, xfer_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               err_q, err_d;
    logic               abort_q, abort_d;
    // Commands that finish without bus activity spend one extra cycle in
    // DONE so their done pulse lands two cycles after start is accepted.
    logic               hold_q, hold_d;

    logic               misaligned;

    assign misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            addr_q  <= '0;
            buf_q   <= '0;
            rem_q   <= '0;
            xfer_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            rem_q   <= rem_d;
            xfer_q  <= xfer_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            abort_q <= abort_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        rem_d   = rem_q;
        xfer_d  = xfer_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        abort_d = abort_q;
        hold_d  = hold_q;

        // Abort is remembered for the whole command, acted on after a write.
        if (state_q != S_IDLE && abort) begin
            abort_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    rem_d   = word_count;
                    xfer_d  = '0;
                    tmo_d   = '0;
                    abort_d = 1'b0;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        hold_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (word_count == '0) begin
                        err_d   = 1'b0;
                        hold_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        addr_d  = src_addr;
                        state_d = S_RD;
                    end
                end
            end

            S_RD: begin
                if (mem_ack) begin
                    buf_d   = mem_read_data;
                    src_d   = src_q + 32'd4;
                    addr_d  = dst_q;
                    tmo_d   = '0;
                    state_d = S_WR;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_WR: begin
                if (mem_ack) begin
                    dst_d  = dst_q + 32'd4;
                    xfer_d = xfer_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    tmo_d  = '0;
                    if (rem_q == CNT_W'(1) || abort_q || abort) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = src_q;
                        state_d = S_RD;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_DONE: begin
                if (hold_q) begin
                    hold_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Requests come straight from the state register, masked in the ack cycle.
    assign mem_read       = (state_q == S_RD) & ~mem_ack;
    assign mem_write      = (state_q == S_WR) & ~mem_ack;
    assign mem_addr       = addr_q;
    assign mem_write_data = buf_q;
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE) & ~hold_q;
    assign error          = err_q;
    assign xfer_count     = xfer_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_mem_dma_master.sv
module tb_mem_dma_master;

  localparam int TMO = 16;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic        start, abort;
  logic [31:0] src, dst;
  logic [15:0] wc;
  logic        busy, done, error;
  logic [15:0] xfer_count;
  logic        mem_read, mem_write, mem_ack;
  logic [31:0] mem_addr, mem_rdata, mem_write_data;
  logic [1:0]  dbg_state;

  mem_dma_master #(.TIMEOUT(TMO), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .src_addr(src), .dst_addr(dst), .word_count(wc),
    .busy(busy), .done(done), .error(error), .xfer_count(xfer_count),
    .mem_read(mem_read), .mem_write(mem_write), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_read_data(mem_rdata),
    .mem_write_data(mem_write_data), .dbg_state(dbg_state)
  );

  // responder model: rmem is the read image, wmem collects writes
  logic [31:0] rmem [1024];
  logic [31:0] wmem [1024];
  logic clr_w = 1'b0, no_ack = 1'b0, rand_lat = 1'b0;
  int   fix_lat = 1;
  int   wcnt = 0, tgt = 1;

  initial mem_ack = 1'b0;
  initial mem_rdata = 32'h0;

  always @(posedge clk) begin
    if (clr_w) for (int i = 0; i < 1024; i++) wmem[i] <= 32'h0;
    if (!reset_n) begin
      mem_ack <= 1'b0;
      wcnt = 0;
    end else if (mem_ack) begin
      mem_ack <= 1'b0;
      wcnt = 0;
    end else if ((mem_read || mem_write) && !no_ack) begin
      if (wcnt == 0) tgt = rand_lat ? int'($urandom_range(1, 5)) : fix_lat;
      wcnt++;
      if (wcnt >= tgt) begin
        mem_ack <= 1'b1;
        wcnt = 0;
        if (mem_read) mem_rdata <= rmem[mem_addr[11:2]];
        else wmem[mem_addr[11:2]] <= mem_write_data;
      end
    end
  end

  // bus monitor: activity counters and protocol violation count
  int rd_cyc = 0, wr_cyc = 0, done_cnt = 0, viol = 0;
  logic prev_rd = 1'b0, prev_wr = 1'b0;
  logic [31:0] prev_addr = 32'h0, prev_wd = 32'h0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_read && mem_write) viol++;
      if ((mem_read || mem_write) && mem_ack) viol++;
      if ((mem_read && prev_rd) || (mem_write && prev_wr))
        if (mem_addr !== prev_addr || mem_write_data !== prev_wd) viol++;
      if (mem_read) rd_cyc++;
      if (mem_write) wr_cyc++;
      if (done) done_cnt++;
    end
    prev_rd   = mem_read && reset_n;
    prev_wr   = mem_write && reset_n;
    prev_addr = mem_addr;
    prev_wd   = mem_write_data;
  end

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic verify(input string tag, input int didx, input int n, input logic [31:0] base);
    logic [31:0] e;
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(i));
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      check(tag, wmem[didx + i], e);
    end
  endtask

  // driver tasks
  task automatic clear_wmem();
    @(negedge clk);
    clr_w = 1'b1;
    @(negedge clk);
    clr_w = 1'b0;
  endtask

  // returns at the negedge of cycle N+1 (start sampled at edge N)
  task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(negedge clk);
    src = s; dst = d; wc = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // cyc = k means done seen in cycle N+k
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) check("done_seen", 32'd0, 32'd1);
  endtask

  int cyc, d0, rd0, wr0, v0, rises;
  logic prv, fired, saw_wr;

  initial begin
    start = 1'b0; abort = 1'b0; src = '0; dst = '0; wc = '0;
    reset_n = 1'b0;
    for (int i = 0; i < 1024; i++) rmem[i] = 32'hC0DE0000 + 32'(i);
    for (int i = 0; i < 4; i++) rmem[16'h40 + i] = 32'hA0 + 32'(i);
    clear_wmem();
    @(negedge clk);

    // reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_xfer", 32'(xfer_count), 32'd0);
    check("rst_rd", 32'(mem_read), 32'd0);
    check("rst_wr", 32'(mem_write), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_write_data, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // abort in IDLE is ignored; then 4-word copy with 4-cycle latency
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    fix_lat = 4;
    #1 d0 = done_cnt; v0 = viol;
    launch(32'h100, 32'h200, 16'd4);
    check("cp_busy_n1", 32'(busy), 32'd1);
    check("cp_rd_n1", 32'(mem_read), 32'd1);
    check("cp_addr_n1", mem_addr, 32'h100);
    wait_done(cyc);
    check("cp_done_cyc", 32'(cyc), 32'd41);
    check("cp_busy_done", 32'(busy), 32'd1);
    @(negedge clk);
    #1;
    check("cp_busy_after", 32'(busy), 32'd0);
    check("cp_done_after", 32'(done), 32'd0);
    check("cp_xfer", 32'(xfer_count), 32'd4);
    check("cp_error", 32'(error), 32'd0);
    check("cp_done_cnt", 32'(done_cnt - d0), 32'd1);
    verify("cp_data", 16'h80, 4, 32'hA0);

    // random 1..5 latency, 6 words
    rand_lat = 1'b1;
    launch(32'h300, 32'h380, 16'd6);
    wait_done(cyc);
    @(negedge clk);
    #1;
    check("rnd_xfer", 32'(xfer_count), 32'd6);
    check("rnd_error", 32'(error), 32'd0);
    verify("rnd_data", 16'hE0, 6, 32'hC0DE00C0);
    check("rnd_viol", 32'(viol - v0), 32'd0);
    rand_lat = 1'b0;

    // zero-length command
    #1 rd0 = rd_cyc; wr0 = wr_cyc;
    launch(32'h100, 32'h200, 16'd0);
    check("zl_busy_n1", 32'(busy), 32'd1);
    check("zl_done_n1", 32'(done), 32'd0);
    wait_done(cyc);
    check("zl_done_cyc", 32'(cyc), 32'd2);
    check("zl_error", 32'(error), 32'd0);
    @(negedge clk);
    #1;
    check("zl_busy_after", 32'(busy), 32'd0);
    check("zl_bus", 32'(rd_cyc - rd0 + wr_cyc - wr0), 32'd0);
    check("zl_xfer", 32'(xfer_count), 32'd0);

    // misaligned source, then misaligned destination
    #1 rd0 = rd_cyc; wr0 = wr_cyc;
    launch(32'h102, 32'h200, 16'd4);
    check("ms_err_n1", 32'(error), 32'd1);
    wait_done(cyc);
    check("ms_done_cyc", 32'(cyc), 32'd2);
    launch(32'h100, 32'h201, 16'd4);
    wait_done(cyc);
    check("md_error", 32'(error), 32'd1);
    @(negedge clk);
    #1;
    check("ms_bus", 32'(rd_cyc - rd0 + wr_cyc - wr0), 32'd0);
    check("ms_xfer", 32'(xfer_count), 32'd0);

    // abort during the 2nd read of an 8-word copy
    fix_lat = 2;
    clear_wmem();
    launch(32'h100, 32'h200, 16'd8);
    check("ab_err_clr", 32'(error), 32'd0);
    cyc = 1; rises = 0; prv = 1'b0; fired = 1'b0;
    while (done !== 1'b1 && cyc < 3000) begin
      if (mem_read && !prv) rises++;
      prv = mem_read;
      if (abort) abort = 1'b0;
      else if (rises == 2 && mem_read && !fired) begin
        abort = 1'b1;
        fired = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    abort = 1'b0;
    check("ab_done_seen", 32'(done), 32'd1);
    check("ab_fired", 32'(fired), 32'd1);
    @(negedge clk);
    #1;
    check("ab_xfer", 32'(xfer_count), 32'd2);
    check("ab_error", 32'(error), 32'd0);
    verify("ab_data", 16'h80, 2, 32'hA0);
    check("ab_w2_untouched", wmem[16'h82], 32'd0);

    // responder never acks
    no_ack = 1'b1;
    #1 rd0 = rd_cyc; wr0 = wr_cyc;
    launch(32'h100, 32'h200, 16'd3);
    wait_done(cyc);
    check("to_done_cyc", 32'(cyc), 32'd17);
    check("to_error", 32'(error), 32'd1);
    check("to_xfer", 32'(xfer_count), 32'd0);
    @(negedge clk);
    #1;
    check("to_rd_cycles", 32'(rd_cyc - rd0), 32'd16);
    check("to_wr_cycles", 32'(wr_cyc - wr0), 32'd0);
    check("to_busy_after", 32'(busy), 32'd0);
    no_ack = 1'b0;
    fix_lat = 1;
    launch(32'h104, 32'h210, 16'd1);
    check("to_err_clr", 32'(error), 32'd0);
    wait_done(cyc);
    check("to_next_cyc", 32'(cyc), 32'd5);
    check("to_next_xfer", 32'(xfer_count), 32'd1);
    @(negedge clk);
    check("to_next_data", wmem[16'h84], 32'hA1);

    // asynchronous reset during a write
    fix_lat = 3;
    clear_wmem();
    launch(32'h100, 32'h200, 16'd4);
    saw_wr = 1'b0;
    for (int i = 0; i < 100 && !saw_wr; i++) begin
      if (mem_write) saw_wr = 1'b1;
      else @(negedge clk);
    end
    check("rs_saw_wr", 32'(saw_wr), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rs_wr", 32'(mem_write), 32'd0);
    check("rs_rd", 32'(mem_read), 32'd0);
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_done", 32'(done), 32'd0);
    check("rs_xfer", 32'(xfer_count), 32'd0);
    check("rs_addr", mem_addr, 32'd0);
    check("rs_wdata", mem_write_data, 32'd0);
    check("rs_state", 32'(dbg_state), 32'd0);
    #1 d0 = done_cnt;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rs_no_done", 32'(done_cnt - d0), 32'd0);
    fix_lat = 1;
    clear_wmem();
    launch(32'h100, 32'h600, 16'd4);
    wait_done(cyc);
    check("rs_copy_cyc", 32'(cyc), 32'd17);
    @(negedge clk);
    #1;
    check("rs_copy_xfer", 32'(xfer_count), 32'd4);
    verify("rs_copy_data", 16'h180, 4, 32'hA0);
    check("all_viol", 32'(viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
